iiitb_rv32i_imem_loader: RTL and testbench
==========================================

# iiitb_rv32i_imem_loader

Program loader and instruction-memory responder for the iiitb_rv32i core. It accepts a byte stream from a host link, assembles little-endian 32-bit words and writes them into a private instruction memory. The core's fetch stage reads the same memory through a registered read port. The block holds the core in reset until a complete program has been received, and it can be re-armed for a reload without a system reset.

## Interface
Parameters:
- DEPTH, 32: instruction words stored; legal range 2..256.
- AW, 5: word-address width; equals clog2(DEPTH).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- RN  in  1  one clock; reset is synchronous and active-high.
- byte_valid  in  1  host byte strobe.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- load_req  in  1  one-cycle pulse that re-arms the loader from RUN.
- fetch_addr  in  32  word address from the core (NPC).
- fetch_data  out  32  instruction word, registered.
- core_hold  out  1  drives the core's RN; high while no valid program is present.
- load_done  out  1  high in RUN.
- err  out  1  sticky format error.
- words_loaded  out  AW+1  words written in the current load.

## Operation
- A byte transfers when byte_valid and byte_ready are both high.
- byte_ready = 1 in IDLE and LOAD. byte_ready = 0 in RUN.
- States:
  - IDLE: the first accepted byte is the word count N.
    - N == 0 or N > DEPTH: set err, stay in IDLE.
    - Otherwise: latch N, clear err, clear words_loaded, go to LOAD.
  - LOAD: bytes are assembled LSB first.
    - On the 4th byte, write the word to mem[words_loaded] in the same cycle and increment words_loaded.
    - After word N: go to CHK if CHECKSUM is compiled in, otherwise go to RUN.
  - CHK: one accepted byte, compared against the running XOR of all data bytes.
    - Match: go to RUN.
    - Mismatch: set err, go to IDLE.
  - RUN:
    - core_hold = 0.
    - load_req: go to IDLE and raise core_hold. Memory keeps its old contents until overwritten.
- core_hold = 1 in every state except RUN.
- Fetch port:
  - fetch_data <= mem[fetch_addr[AW-1:0]] when fetch_addr < DEPTH; otherwise 32'h0.
  - The read is active in every state.
- A read and a write to the same address in the same cycle return the old word (read-before-write).
- Byte counter is 2 bits and wraps 3 -> 0 on each completed word.
- words_loaded saturates at N.

## Timing
- Reset values:
  - State IDLE.
  - byte_ready = 1, core_hold = 1, load_done = 0, err = 0, words_loaded = 0, fetch_data = 0.
  - Byte counter and XOR accumulator = 0.
  - All DEPTH memory words cleared to 0 in the reset cycle.
- RN asserted mid-load: the partial word is discarded and the next cycle is IDLE.
- Fetch latency is 1 cycle: address at edge k, data valid after edge k.
- Final accepted byte (last data byte, or checksum byte when compiled in) at edge k:
  - load_done = 1 and core_hold = 0 after edge k.
  - The core leaves reset at edge k+1.
- load_req at edge k: core_hold = 1 and byte_ready = 1 after edge k.
- load_req outside RUN is ignored.
- load_req together with RN: RN wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - CHK state is present; a checksum byte follows the last word.
  - A mismatch sets err and returns to IDLE. The written words stay in memory but core_hold stays high.
- Not defined:
  - No CHK state and no XOR accumulator.
  - RUN is entered on the last data byte.

## Structure
- Package iiitb_rv32i_pkg holds:
  - The loader state enum (IDLE, LOAD, CHK, RUN).
  - The NOP word 32'h0.
  - The opcode-class constants AR_TYPE, M_TYPE, BR_TYPE, SH_TYPE, shared with the core.
- Sub-module iiitb_rv32i_byte_assembler:
  - 2-bit byte counter plus 24-bit shift register.
  - Emits word_valid and a 32-bit word on the 4th byte.

## Test plan
- Reset, then send 02, 00 83 20 02, 80 93 20 02 (no checksum) → load_done rises on the 9th byte. A fetch of address 1 then returns 32'h02209380 one cycle later, and core_hold = 0.
- Count byte 00, then count byte 33 with DEPTH = 32 → err = 1, state stays IDLE, byte_ready = 1. A following valid count of 01 clears err.
- With IMEM_LOADER_CHECKSUM_EN, load 1 word 00 83 20 02:
  - Checksum A1 → RUN.
  - Checksum A0 → err = 1, core_hold = 1, IDLE.
- Assert RN after 2 of 4 bytes, then do a full load of 1 word 78 56 34 12 → address 0 reads 32'h12345678, with no leftover bytes mixed in.
- In RUN, pulse load_req, then reload 1 word FF FF FF FF → core_hold is high for the whole load. Address 0 = 32'hFFFFFFFF; address 1 keeps its previous value.
- Fetch address 40 with DEPTH = 32 → fetch_data = 0. Back-to-back fetch addresses 0,1,2 → data appears at 1-cycle latency on consecutive cycles.

Source files
------------

// File: rtl/iiitb_rv32i_pkg.sv
// Shared iiitb_rv32i types: loader state encoding, NOP word and opcode-class constants.
package iiitb_rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    RUN  = 2'd3
  } ldr_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Opcode classes decoded by the core
  localparam logic [6:0] AR_TYPE = 7'b0110011;
  localparam logic [6:0] M_TYPE  = 7'b0000011;
  localparam logic [6:0] BR_TYPE = 7'b1100011;
  localparam logic [6:0] SH_TYPE = 7'b0100011;

endpackage

// File: rtl/iiitb_rv32i_byte_assembler.sv
// Packs accepted bytes LSB first into 32-bit words; word_valid is combinational on the 4th byte.
module iiitb_rv32i_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_fire) begin
      cnt   <= cnt + 2'd1;
      shreg <= {byte_data, shreg[23:8]};
    end
  end

  // Earliest byte has shifted down to shreg[7:0] by the time the 4th arrives
  assign word_valid = byte_fire && (cnt == 2'd3);
  assign word       = {byte_data, shreg};

endmodule

// File: rtl/iiitb_rv32i_imem_loader.sv
// Byte-stream program loader plus 1-cycle registered fetch port; holds the core until a program is in.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined; byte_ready drops only in RUN.
module iiitb_rv32i_imem_loader
  import iiitb_rv32i_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          RN,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic          load_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          core_hold,
  output logic          load_done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  ldr_state_t  state, next_state;
  logic [AW:0] n_words;
  logic [31:0] mem [DEPTH];
  logic        byte_fire, load_fire, count_ok, last_word;
  logic        word_valid;
  logic [31:0] word;

  assign byte_ready = (state != RUN);
  assign core_hold  = (state != RUN);
  assign load_done  = (state == RUN);
  assign byte_fire  = byte_valid && byte_ready;
  assign load_fire  = byte_fire && (state == LOAD);
  assign count_ok   = (byte_data != 8'd0) && (int'(byte_data) <= DEPTH);
  assign last_word  = word_valid && ((words_loaded + (AW+1)'(1)) == n_words);

  iiitb_rv32i_byte_assembler u_asm (
    .clk        (clk),
    .rst        (RN),
    .byte_fire  (load_fire),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;

  always_ff @(posedge clk) begin
    if (RN)
      xor_acc <= 8'd0;
    else if (state == IDLE && byte_fire && count_ok)
      xor_acc <= 8'd0;
    else if (load_fire)
      xor_acc <= xor_acc ^ byte_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (RN) state <= IDLE;
    else    state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (byte_fire && count_ok) next_state = LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LOAD: if (last_word) next_state = CHK;
      CHK:  if (byte_fire) next_state = (byte_data == xor_acc) ? RUN : IDLE;
`else
      LOAD: if (last_word) next_state = RUN;
`endif
      RUN:  if (load_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Fetch reads the pre-write word, so a same-address write is seen one cycle later
  always_ff @(posedge clk) begin
    if (RN) begin
      n_words      <= '0;
      words_loaded <= '0;
      err          <= 1'b0;
      fetch_data   <= NOP;
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
    end else begin
      fetch_data <= (fetch_addr < 32'(DEPTH)) ? mem[fetch_addr[AW-1:0]] : NOP;
      if (state == IDLE && byte_fire) begin
        if (count_ok) begin
          n_words      <= (AW+1)'(byte_data);
          words_loaded <= '0;
          err          <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (word_valid) begin
        mem[words_loaded[AW-1:0]] <= word;
        words_loaded              <= words_loaded + (AW+1)'(1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == CHK && byte_fire && byte_data != xor_acc) err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_iiitb_rv32i_imem_loader.sv
// Directed bench for the imem loader with a byte-queue reference model checked every cycle.
module tb_iiitb_rv32i_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk;
  logic          rn;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          load_req;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_data;
  logic          core_hold;
  logic          load_done;
  logic          err;
  logic [AW:0]   words_loaded;

  iiitb_rv32i_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .RN           (rn),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .load_req     (load_req),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bytes of the current program (count first) plus memory image
  logic [31:0] mem_m [DEPTH];
  logic [7:0]  q [$];
  bit          run_m;
  bit          err_m;
  int          wl_m;
  logic [31:0] fd_m;
  bit          live = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    int n, nb;
    logic [7:0] x;
    if (q.size() == 0) begin
      if (b == 8'd0 || int'(b) > DEPTH) err_m = 1'b1;
      else begin
        err_m = 1'b0;
        wl_m  = 0;
        q.push_back(b);
      end
    end else begin
      q.push_back(b);
      n  = int'(q[0]);
      nb = q.size() - 1;
      if (nb <= 4*n) begin
        if (nb % 4 == 0) begin
          mem_m[nb/4 - 1] = {q[nb], q[nb-1], q[nb-2], q[nb-3]};
          wl_m = nb / 4;
        end
        if (nb == 4*n && !CK) begin
          run_m = 1'b1;
          q.delete();
        end
      end else begin
        x = 8'd0;
        for (int i = 1; i <= 4*n; i++) x = x ^ q[i];
        if (x == b) run_m = 1'b1;
        else        err_m = 1'b1;
        q.delete();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rn) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
      run_m = 1'b0;
      err_m = 1'b0;
      wl_m  = 0;
      q.delete();
      fd_m  = 32'h0;
    end else begin
      fd_m = (fetch_addr < DEPTH) ? mem_m[fetch_addr[AW-1:0]] : 32'h0;
      if (run_m) begin
        if (load_req) run_m = 1'b0;
      end else if (byte_valid) begin
        model_byte(byte_data);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("byte_ready",   {31'd0, byte_ready}, {31'd0, !run_m});
      chk("core_hold",    {31'd0, core_hold},  {31'd0, !run_m});
      chk("load_done",    {31'd0, load_done},  {31'd0, run_m});
      chk("err",          {31'd0, err},        {31'd0, err_m});
      chk("words_loaded", 32'(words_loaded),   32'(wl_m));
      chk("fetch_data",   fetch_data,          fd_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_addr = a;
    tick();
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    rn = 1'b1; byte_valid = 1'b0; byte_data = 8'h0; load_req = 1'b0; fetch_addr = 32'h0;
    tick();
    live = 1'b1;
    tick();
    rn = 1'b0;
    chk("rst_hold",  {31'd0, core_hold},  32'd1);
    chk("rst_ready", {31'd0, byte_ready}, 32'd1);
    chk("rst_done",  {31'd0, load_done},  32'd0);
    chk("rst_err",   {31'd0, err},        32'd0);
    chk("rst_wl",    32'(words_loaded),   32'd0);
    chk("rst_fd",    fetch_data,          32'd0);

    // Two-word program
    send(8'h02);
    send(8'h00); send(8'h83); send(8'h20); send(8'h02);
    chk("wl_after_w0", 32'(words_loaded), 32'd1);
    send(8'h80); send(8'h93); send(8'h20);
    chk("done_before_last", {31'd0, load_done}, 32'd0);
    send(8'h02);
    if (CK) begin
      chk("done_before_ck", {31'd0, load_done}, 32'd0);
      send(8'h90);
    end
    chk("done_rise", {31'd0, load_done}, 32'd1);
    chk("hold_fall", {31'd0, core_hold}, 32'd0);
    chk("wl_final",  32'(words_loaded),  32'd2);
    fetch(32'd1); chk("fetch_a1", fetch_data, 32'h02209380);
    fetch(32'd0); chk("b2b_a0",   fetch_data, 32'h02208300);
    fetch(32'd1); chk("b2b_a1",   fetch_data, 32'h02209380);
    fetch(32'd2); chk("b2b_a2",   fetch_data, 32'h00000000);
    fetch(32'd40); chk("fetch_oor", fetch_data, 32'h00000000);

    // Reload word 0 only
    pulse_load_req();
    chk("req_hold",  {31'd0, core_hold},  32'd1);
    chk("req_ready", {31'd0, byte_ready}, 32'd1);
    send(8'h01); send(8'hFF); send(8'hFF);
    chk("reload_hold_mid", {31'd0, core_hold}, 32'd1);
    send(8'hFF); send(8'hFF);
    if (CK) send(8'h00);
    chk("reload_done", {31'd0, load_done}, 32'd1);
    fetch(32'd0); chk("reload_a0", fetch_data, 32'hFFFFFFFF);
    fetch(32'd1); chk("reload_a1", fetch_data, 32'h02209380);

    // load_req together with reset: reset wins and clears memory
    load_req = 1'b1; rn = 1'b1;
    tick();
    load_req = 1'b0; rn = 1'b0;
    chk("rnreq_hold", {31'd0, core_hold}, 32'd1);
    fetch(32'd0); chk("rnreq_mem", fetch_data, 32'h0);

    // load_req outside RUN is ignored
    pulse_load_req();
    chk("idle_req_ready", {31'd0, byte_ready}, 32'd1);

    // Bad count bytes
    send(8'h00);
    chk("cnt0_err",   {31'd0, err},        32'd1);
    chk("cnt0_ready", {31'd0, byte_ready}, 32'd1);
    send(8'h33);
    chk("cnt33_err",  {31'd0, err},        32'd1);
    chk("cnt33_hold", {31'd0, core_hold},  32'd1);
    send(8'h01);
    chk("cnt1_clr",   {31'd0, err},        32'd0);

    // Reset after 2 of 4 bytes, then a clean load
    send(8'h11); send(8'h22);
    rn = 1'b1; tick(); rn = 1'b0;
    chk("midrst_wl", 32'(words_loaded), 32'd0);
    send(8'h01);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    if (CK) send(8'h08);
    chk("clean_done", {31'd0, load_done}, 32'd1);
    fetch(32'd0); chk("clean_a0", fetch_data, 32'h12345678);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_load_req();
    send(8'h01); send(8'h00); send(8'h83); send(8'h20); send(8'h02);
    send(8'hA1);
    chk("ck_good_done", {31'd0, load_done}, 32'd1);
    pulse_load_req();
    send(8'h01); send(8'h00); send(8'h83); send(8'h20); send(8'h02);
    send(8'hA0);
    chk("ck_bad_err",  {31'd0, err},       32'd1);
    chk("ck_bad_hold", {31'd0, core_hold}, 32'd1);
    chk("ck_bad_done", {31'd0, load_done}, 32'd0);
    fetch(32'd0); chk("ck_bad_mem", fetch_data, 32'h02208300);
`endif

    tick();
    live = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
